// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and the stall/flush/bubble bundle.
// Watchdog support (HAZARD_WATCHDOG_EN) is selected in the sequencer and top, not here.
package hazard_pkg;

   localparam int unsigned DefRegAddrW = 5;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MC_WAIT = 2'd1,
      MC_DONE = 2'd2
   } hc_state_t;

   typedef struct packed {
      logic stall_if;
      logic stall_id;
      logic stall_ex;
      logic flush_id;
      logic flush_ex;
      logic bubble_mem;
   } hazard_ctrl_t;

endpackage

// File: rtl/hazard_mc_sequencer.sv
// Multi-cycle EX unit start/done handshake FSM.
// With HAZARD_WATCHDOG_EN defined, an MC_WAIT watchdog aborts the op after MC_TIMEOUT cycles.
module hazard_mc_sequencer
   import hazard_pkg::*;
`ifdef HAZARD_WATCHDOG_EN
#(
   parameter int unsigned MC_TIMEOUT = 64
)
`endif
(
   input  logic      clk_i,
   input  logic      rst_ni,
   input  logic      ex_mc_op_i,
   input  logic      ex_branch_taken_i,
   input  logic      mc_done_i,
   output hc_state_t state_o,
`ifdef HAZARD_WATCHDOG_EN
   output logic      mc_timeout_o,
`endif
   output logic      mc_start_o
);

   hc_state_t state_q, state_d;

`ifdef HAZARD_WATCHDOG_EN
   localparam int unsigned WdW = $clog2(MC_TIMEOUT + 1);
   logic [WdW-1:0] wd_q, wd_d;
`endif

   always_comb begin
      state_d    = state_q;
      mc_start_o = 1'b0;
`ifdef HAZARD_WATCHDOG_EN
      wd_d         = wd_q;
      mc_timeout_o = 1'b0;
`endif
      case (state_q)
         RUN: begin
            if (ex_mc_op_i && !ex_branch_taken_i) begin
               state_d    = MC_WAIT;
               mc_start_o = 1'b1;
`ifdef HAZARD_WATCHDOG_EN
               wd_d = '0;
`endif
            end
         end
         MC_WAIT: begin
            // A done pulse on the timeout cycle still takes the normal completion path
            if (mc_done_i) begin
               state_d = MC_DONE;
`ifdef HAZARD_WATCHDOG_EN
            end else if (wd_q == WdW'(MC_TIMEOUT - 1)) begin
               state_d      = RUN;
               mc_timeout_o = 1'b1;
            end else begin
               wd_d = wd_q + WdW'(1);
`endif
            end
         end
         MC_DONE: state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RUN;
`ifdef HAZARD_WATCHDOG_EN
         wd_q <= '0;
`endif
      end else begin
         state_q <= state_d;
`ifdef HAZARD_WATCHDOG_EN
         wd_q <= wd_d;
`endif
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard scheduler: load-use stalls, branch flushes, multi-cycle EX stalls, stall counter.
// Optional MC_WAIT watchdog and mc_timeout_o port are enabled by defining HAZARD_WATCHDOG_EN.
module hazard_controller
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = DefRegAddrW,
   parameter int unsigned PERF_W     = 32
`ifdef HAZARD_WATCHDOG_EN
   ,
   parameter int unsigned MC_TIMEOUT = 64
`endif
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
   input  logic                  id_uses_rs1_i,
   input  logic                  id_uses_rs2_i,
   input  logic                  ex_mem_read_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
   input  logic                  ex_branch_taken_i,
   input  logic                  ex_mc_op_i,
   input  logic                  mc_done_i,
   output logic                  mc_start_o,
   output logic                  stall_if_o,
   output logic                  stall_id_o,
   output logic                  stall_ex_o,
   output logic                  flush_id_o,
   output logic                  flush_ex_o,
   output logic                  bubble_mem_o,
   output logic                  mc_busy_o,
`ifdef HAZARD_WATCHDOG_EN
   output logic                  mc_timeout_o,
`endif
   output logic [PERF_W-1:0]     perf_stall_cnt_o
);

   hc_state_t    state;
   logic         seq_start;
   logic         load_use;
   hazard_ctrl_t ctrl;
   logic [PERF_W-1:0] perf_q, perf_d;

`ifdef HAZARD_WATCHDOG_EN
   logic seq_timeout;

   hazard_mc_sequencer #(
      .MC_TIMEOUT (MC_TIMEOUT)
   ) u_seq (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .ex_mc_op_i        (ex_mc_op_i),
      .ex_branch_taken_i (ex_branch_taken_i),
      .mc_done_i         (mc_done_i),
      .state_o           (state),
      .mc_timeout_o      (seq_timeout),
      .mc_start_o        (seq_start)
   );

   assign mc_timeout_o = seq_timeout & rst_ni;
`else
   hazard_mc_sequencer u_seq (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .ex_mc_op_i        (ex_mc_op_i),
      .ex_branch_taken_i (ex_branch_taken_i),
      .mc_done_i         (mc_done_i),
      .state_o           (state),
      .mc_start_o        (seq_start)
   );
`endif

   // rd == x0 never creates a real dependency
   assign load_use = ex_mem_read_i && (ex_rd_addr_i != '0) &&
                     ((id_uses_rs1_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                      (id_uses_rs2_i && (id_rs2_addr_i == ex_rd_addr_i)));

   always_comb begin
      ctrl = '0;
      case (state)
         RUN: begin
            if (ex_branch_taken_i) begin
               ctrl.flush_id = 1'b1;
               ctrl.flush_ex = 1'b1;
            end else if (ex_mc_op_i) begin
               ctrl.stall_if   = 1'b1;
               ctrl.stall_id   = 1'b1;
               ctrl.stall_ex   = 1'b1;
               ctrl.bubble_mem = 1'b1;
            end else if (load_use) begin
               ctrl.stall_if = 1'b1;
               ctrl.stall_id = 1'b1;
               ctrl.flush_ex = 1'b1;
            end
         end
         MC_WAIT: begin
            ctrl.stall_if   = 1'b1;
            ctrl.stall_id   = 1'b1;
            ctrl.stall_ex   = 1'b1;
            ctrl.bubble_mem = 1'b1;
`ifdef HAZARD_WATCHDOG_EN
            // Abandon the hung op: kill it in EX but keep the younger instructions held
            if (seq_timeout) begin
               ctrl.stall_ex = 1'b0;
               ctrl.flush_ex = 1'b1;
            end
`endif
         end
         MC_DONE: begin
            if (load_use) begin
               ctrl.stall_if = 1'b1;
               ctrl.stall_id = 1'b1;
               ctrl.flush_ex = 1'b1;
            end
         end
         default: ctrl = '0;
      endcase
      if (!rst_ni) ctrl = '0;
   end

   assign stall_if_o   = ctrl.stall_if;
   assign stall_id_o   = ctrl.stall_id;
   assign stall_ex_o   = ctrl.stall_ex;
   assign flush_id_o   = ctrl.flush_id;
   assign flush_ex_o   = ctrl.flush_ex;
   assign bubble_mem_o = ctrl.bubble_mem;
   assign mc_start_o   = seq_start & rst_ni;
   assign mc_busy_o    = (state != RUN) & rst_ni;

   always_comb begin
      perf_d = perf_q;
      if (ctrl.stall_if && (perf_q != '1)) perf_d = perf_q + PERF_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) perf_q <= '0;
      else         perf_q <= perf_d;
   end

   assign perf_stall_cnt_o = perf_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed cases plus random stimulus vs. a reference model.
// Define HAZARD_WATCHDOG_EN to also exercise the watchdog (MC_TIMEOUT = 8).
module tb_hazard_controller;

   localparam int unsigned WdTo = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] rs1, rs2, rd;
   logic       u1, u2, mr, br, mcop, done;

   logic        mc_start, stall_if, stall_id, stall_ex, flush_id, flush_ex, bubble_mem, mc_busy;
   logic [31:0] cnt;
   logic        s_mc_start, s_stall_if, s_stall_id, s_stall_ex, s_flush_id, s_flush_ex;
   logic        s_bubble_mem, s_mc_busy;
   logic [3:0]  s_cnt;
   logic        tmo, s_tmo;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: pipeline phase 0 = normal, 1 = waiting on multi-cycle unit, 2 = result slot
   int          m_phase;
   int unsigned m_wait;
   longint unsigned m_cnt;
   int unsigned m_scnt;

   always #5 clk = ~clk;

`ifdef HAZARD_WATCHDOG_EN
   hazard_controller #(.REG_ADDR_W(5), .PERF_W(32), .MC_TIMEOUT(WdTo)) dut (
`else
   hazard_controller #(.REG_ADDR_W(5), .PERF_W(32)) dut (
`endif
      .clk_i(clk), .rst_ni(rst_n),
      .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_uses_rs1_i(u1), .id_uses_rs2_i(u2),
      .ex_mem_read_i(mr), .ex_rd_addr_i(rd), .ex_branch_taken_i(br), .ex_mc_op_i(mcop),
      .mc_done_i(done), .mc_start_o(mc_start), .stall_if_o(stall_if), .stall_id_o(stall_id),
      .stall_ex_o(stall_ex), .flush_id_o(flush_id), .flush_ex_o(flush_ex),
      .bubble_mem_o(bubble_mem), .mc_busy_o(mc_busy),
`ifdef HAZARD_WATCHDOG_EN
      .mc_timeout_o(tmo),
`endif
      .perf_stall_cnt_o(cnt)
   );

`ifdef HAZARD_WATCHDOG_EN
   hazard_controller #(.REG_ADDR_W(5), .PERF_W(4), .MC_TIMEOUT(WdTo)) dut_sat (
`else
   hazard_controller #(.REG_ADDR_W(5), .PERF_W(4)) dut_sat (
`endif
      .clk_i(clk), .rst_ni(rst_n),
      .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_uses_rs1_i(u1), .id_uses_rs2_i(u2),
      .ex_mem_read_i(mr), .ex_rd_addr_i(rd), .ex_branch_taken_i(br), .ex_mc_op_i(mcop),
      .mc_done_i(done), .mc_start_o(s_mc_start), .stall_if_o(s_stall_if),
      .stall_id_o(s_stall_id), .stall_ex_o(s_stall_ex), .flush_id_o(s_flush_id),
      .flush_ex_o(s_flush_ex), .bubble_mem_o(s_bubble_mem), .mc_busy_o(s_mc_busy),
`ifdef HAZARD_WATCHDOG_EN
      .mc_timeout_o(s_tmo),
`endif
      .perf_stall_cnt_o(s_cnt)
   );

`ifndef HAZARD_WATCHDOG_EN
   assign tmo   = 1'b0;
   assign s_tmo = 1'b0;
`endif

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] vec();
      return {mc_start, stall_if, stall_id, stall_ex, flush_id, flush_ex, bubble_mem, mc_busy};
   endfunction

   function automatic logic [7:0] svec();
      return {s_mc_start, s_stall_if, s_stall_id, s_stall_ex, s_flush_id, s_flush_ex,
              s_bubble_mem, s_mc_busy};
   endfunction

   task automatic idle();
      rs1 = '0; rs2 = '0; rd = '0; u1 = 0; u2 = 0; mr = 0; br = 0; mcop = 0; done = 0;
   endtask

   task automatic model_reset();
      m_phase = 0; m_wait = 0; m_cnt = 0; m_scnt = 0;
   endtask

   // Called at a negedge with inputs applied; checks, advances the model, returns at next negedge.
   task automatic step(input string tag);
      logic       lu, to;
      logic [7:0] e;
      #1;
      lu = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      to = 1'b0;
      // bits: {mc_start, stall_if, stall_id, stall_ex, flush_id, flush_ex, bubble_mem, mc_busy}
      e  = 8'b0000_0000;
      if (m_phase == 0) begin
         if (br)        e = 8'b0000_1100;
         else if (mcop) e = 8'b1111_0010;
         else if (lu)   e = 8'b0110_0100;
      end else if (m_phase == 1) begin
`ifdef HAZARD_WATCHDOG_EN
         to = !done && (m_wait == WdTo - 1);
`endif
         e = to ? 8'b0110_0111 : 8'b0111_0011;
      end else begin
         e = lu ? 8'b0110_0101 : 8'b0000_0001;
      end
      chk({tag, "_ctrl"}, 64'(vec()), 64'(e));
      chk({tag, "_cnt"}, 64'(cnt), m_cnt);
      chk({tag, "_sat_ctrl"}, 64'(svec()), 64'(e));
      chk({tag, "_sat_cnt"}, 64'(s_cnt), 64'(m_scnt));
`ifdef HAZARD_WATCHDOG_EN
      chk({tag, "_tmo"}, 64'({tmo, s_tmo}), 64'({to, to}));
`endif
      if (e[6]) begin
         if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
         if (m_scnt < 15) m_scnt++;
      end
      case (m_phase)
         0: if (!br && mcop) begin m_phase = 1; m_wait = 0; end
         1: begin
            if (done)    m_phase = 2;
            else if (to) m_phase = 0;
            else         m_wait++;
         end
         default: m_phase = 0;
      endcase
      @(negedge clk);
   endtask

   task automatic reset_check(input string tag);
      #1;
      chk({tag, "_ctrl"}, 64'(vec()), 64'd0);
      chk({tag, "_cnt"}, 64'(cnt), 64'd0);
      chk({tag, "_sat_ctrl"}, 64'(svec()), 64'd0);
      chk({tag, "_sat_cnt"}, 64'(s_cnt), 64'd0);
      chk({tag, "_tmo"}, 64'({tmo, s_tmo}), 64'd0);
   endtask

   initial begin
      idle();
      mcop  = 1; br = 0; mr = 1; rd = 5; rs1 = 5; u1 = 1;
      rst_n = 0;
      reset_check("reset");
      @(negedge clk);
      rst_n = 1;
      idle();
      model_reset();

      // load-use on rs2, then rd == x0, then branch beating a load-use match
      mr = 1; rd = 5; rs2 = 5; u2 = 1; step("lu_rs2");
      rd = 0;                           step("lu_x0");
      rd = 5; br = 1;                   step("br_over_lu");
      idle();                           step("idle");
      chk("lu_perf", 64'(cnt), 64'd1);

      // 10-cycle multi-cycle op with ex_mc_op held through the result slot
      mcop = 1; step("mc_start");
      for (int i = 1; i <= 10; i++) begin
         done = (i == 10);
         step($sformatf("mc_wait%0d", i));
      end
      done = 0; step("mc_done");
      idle();   step("mc_after");
      chk("mc_perf", 64'(cnt), 64'd12);

      // 20-cycle op saturates the 4-bit counter
      mcop = 1; step("sat_start");
      mcop = 0;
      for (int i = 1; i <= 20; i++) begin
         done = (i == 20);
         step($sformatf("sat_wait%0d", i));
      end
      done = 0; step("sat_done");
      step("sat_after");
      chk("sat_hold", 64'(s_cnt), 64'd15);
      chk("sat_wide", 64'(cnt), 64'd33);

      // reset asserted in the 4th MC_WAIT cycle
      mcop = 1; step("rst_start");
      mcop = 0;
      for (int i = 1; i <= 3; i++) step($sformatf("rst_wait%0d", i));
      mcop  = 1;
      rst_n = 0;
      reset_check("rst_mid");
      @(negedge clk);
      rst_n = 1;
      idle();
      model_reset();
      step("rst_after");

`ifdef HAZARD_WATCHDOG_EN
      mcop = 1; step("wd_start");
      mcop = 0;
      for (int i = 1; i <= WdTo; i++) step($sformatf("wd_wait%0d", i));
      step("wd_after");
      mcop = 1; step("wd2_start");
      mcop = 0;
      for (int i = 1; i <= WdTo; i++) begin
         done = (i == WdTo);
         step($sformatf("wd2_wait%0d", i));
      end
      done = 0; step("wd2_done");
`endif

      for (int n = 0; n < 2000; n++) begin
         rs1  = 5'($urandom_range(0, 3));
         rs2  = 5'($urandom_range(0, 3));
         rd   = 5'($urandom_range(0, 3));
         u1   = 1'($urandom_range(0, 1));
         u2   = 1'($urandom_range(0, 1));
         mr   = ($urandom_range(0, 2) == 0);
         br   = ($urandom_range(0, 7) == 0);
         mcop = ($urandom_range(0, 7) == 0);
         done = ($urandom_range(0, 5) == 0);
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
